// File: rtl/led_fade_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_fade_ctrl_if
//  Brief    : Control/status bundle between a brightness source and
//             led_fade_ctrl (run/mode/step inputs, duty and status outputs).
//  Revision : 1.0 - initial release
// ============================================================================
interface led_fade_ctrl_if #(
    parameter int DUTY_W = 4
);
    logic              en;
    logic              mode;
    logic              inc;
    logic              dec;
    logic [DUTY_W-1:0] duty;
    logic              at_max;
    logic              at_min;
    logic [2:0]        state;

    // Controller side: drives the requests, observes duty and status
    modport master (
        output en, mode, inc, dec,
        input  duty, at_max, at_min, state
    );

    // Sequencer side: consumes the requests, produces duty and status
    modport slave (
        input  en, mode, inc, dec,
        output duty, at_max, at_min, state
    );
endinterface
`default_nettype wire

// File: rtl/led_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_fade_ctrl
//  Brief    : Brightness sequencer for a PWM LED dimmer. Manual mode steps the
//             duty on inc/dec pulses; breathe mode ramps up, holds, ramps down
//             and holds, stepping once per prescaler tick.
//  Revision : 1.0 - initial release
// ============================================================================
module led_fade_ctrl #(
    parameter int DUTY_W     = 4,
    parameter int STEP_DIV   = 65536,
    parameter int HOLD_STEPS = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    led_fade_ctrl_if.slave     bus
);
    localparam int c_PRESC_W = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
    localparam int c_HOLD_W  = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [DUTY_W-1:0]    c_DMAX       = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0]    c_DZERO      = '0;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(STEP_DIV - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(HOLD_STEPS - 1);

    typedef enum logic [2:0] {
        MAN  = 3'd0,
        LOW  = 3'd1,
        UP   = 3'd2,
        HIGH = 3'd3,
        DOWN = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DUTY_W-1:0]     r_duty;
    logic [DUTY_W-1:0]     w_duty_nxt;
    logic [c_HOLD_W-1:0]   r_hold;
    logic [c_HOLD_W-1:0]   w_hold_nxt;
    logic [c_PRESC_W-1:0]  r_presc;
    logic                  w_tick;
    logic [DUTY_W-1:0]     w_duty_inc;
    logic [DUTY_W-1:0]     w_duty_dec;

    assign w_tick     = (r_presc == c_PRESC_LAST);
    assign w_duty_inc = r_duty + 1'b1;
    assign w_duty_dec = r_duty - 1'b1;

    // Step prescaler: counts only while enabled, restarts from zero whenever
    // en drops so the first step after re-enable is a full period away
    always_ff @(posedge clk) begin
        if (reset || !bus.en || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // State, duty and hold-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MAN;
            r_duty  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state logic: mode changes take priority and apply no step on the
    // entry cycle; ramp/hold actions only happen on tick cycles
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_hold_nxt  = r_hold;

        if (bus.en) begin
            case (r_state)
                MAN: begin
                    if (bus.mode) begin
                        w_state_nxt = (r_duty != c_DMAX) ? UP : HIGH;
                        w_hold_nxt  = '0;
                    end else if (bus.inc && !bus.dec && (r_duty != c_DMAX)) begin
                        w_duty_nxt = w_duty_inc;
                    end else if (bus.dec && !bus.inc && (r_duty != c_DZERO)) begin
                        w_duty_nxt = w_duty_dec;
                    end
                end
                UP, HIGH, DOWN, LOW: begin
                    if (!bus.mode) begin
                        w_state_nxt = MAN;
                        w_hold_nxt  = '0;
                    end else if (w_tick) begin
                        case (r_state)
                            UP: begin
                                if (r_duty != c_DMAX) begin
                                    w_duty_nxt = w_duty_inc;
                                end
                                if ((r_duty == c_DMAX) || (w_duty_inc == c_DMAX)) begin
                                    w_state_nxt = HIGH;
                                    w_hold_nxt  = '0;
                                end
                            end
                            DOWN: begin
                                if (r_duty != c_DZERO) begin
                                    w_duty_nxt = w_duty_dec;
                                end
                                if ((r_duty == c_DZERO) || (w_duty_dec == c_DZERO)) begin
                                    w_state_nxt = LOW;
                                    w_hold_nxt  = '0;
                                end
                            end
                            HIGH: begin
                                if (r_hold == c_HOLD_LAST) begin
                                    w_state_nxt = DOWN;
                                    w_hold_nxt  = '0;
                                end else begin
                                    w_hold_nxt = r_hold + 1'b1;
                                end
                            end
                            default: begin
                                if (r_hold == c_HOLD_LAST) begin
                                    w_state_nxt = UP;
                                    w_hold_nxt  = '0;
                                end else begin
                                    w_hold_nxt = r_hold + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    w_state_nxt = MAN;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    assign bus.duty   = r_duty;
    assign bus.at_max = (r_duty == c_DMAX);
    assign bus.at_min = (r_duty == c_DZERO);
    assign bus.state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_fade_ctrl
//  Brief    : Directed self-checking bench for led_fade_ctrl
//             (STEP_DIV=4, HOLD_STEPS=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_fade_ctrl;
    localparam int c_ST_MAN  = 0;
    localparam int c_ST_LOW  = 1;
    localparam int c_ST_UP   = 2;
    localparam int c_ST_HIGH = 3;
    localparam int c_ST_DOWN = 4;

    logic clk;
    logic rst;
    int   r_tests;
    int   r_fails;

    led_fade_ctrl_if #(.DUTY_W(4)) u_if ();

    led_fade_ctrl #(
        .DUTY_W     (4),
        .STEP_DIV   (4),
        .HOLD_STEPS (2)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (u_if.slave)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        r_tests++;
        if (obs !== exp_v) begin
            r_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance n rising edges; returns at the following falling edge
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        u_if.en   = 1'b0;
        u_if.mode = 1'b0;
        u_if.inc  = 1'b0;
        u_if.dec  = 1'b0;
        adv(2);
        rst = 1'b0;
    endtask

    // Start breathe from reset; returns after edge 'n' counted from enable
    task automatic breathe_to(input int n);
        do_reset();
        u_if.en   = 1'b1;
        u_if.mode = 1'b1;
        adv(n);
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;
        @(negedge clk);
        do_reset();

        // ---- reset state ----
        check("rst_duty",   int'(u_if.duty),   0);
        check("rst_state",  int'(u_if.state),  c_ST_MAN);
        check("rst_at_min", int'(u_if.at_min), 1);
        check("rst_at_max", int'(u_if.at_max), 0);

        // ---- 1: manual inc, saturating at 15 ----
        u_if.en  = 1'b1;
        u_if.inc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            adv(1);
            check("man_inc_duty", int'(u_if.duty), (i < 15) ? i : 15);
        end
        u_if.inc = 1'b0;
        check("man_inc_at_max", int'(u_if.at_max), 1);
        check("man_inc_at_min", int'(u_if.at_min), 0);

        // ---- 2: inc&dec together, then dec to 0 ----
        u_if.inc = 1'b1;
        u_if.dec = 1'b1;
        adv(1);
        check("man_incdec", int'(u_if.duty), 15);
        u_if.inc = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            adv(1);
            check("man_dec_duty", int'(u_if.duty), (i < 15) ? 15 - i : 0);
        end
        u_if.dec = 1'b0;
        check("man_dec_at_min", int'(u_if.at_min), 1);
        check("man_dec_at_max", int'(u_if.at_max), 0);

        // en=0: inc ignored and mode change deferred
        u_if.en   = 1'b0;
        u_if.inc  = 1'b1;
        u_if.mode = 1'b1;
        adv(3);
        check("dis_inc_duty",  int'(u_if.duty),  0);
        check("dis_mode_state", int'(u_if.state), c_ST_MAN);
        u_if.inc = 1'b0;
        u_if.en  = 1'b1;
        adv(1);
        check("en_mode_state", int'(u_if.state), c_ST_UP);

        // ---- 3: full breathe period ----
        breathe_to(1);
        check("br_e1_state", int'(u_if.state), c_ST_UP);
        check("br_e1_duty",  int'(u_if.duty),  0);
        adv(2);   // edge 3
        check("br_e3_duty",  int'(u_if.duty),  0);
        adv(1);   // edge 4
        check("br_e4_duty",  int'(u_if.duty),  1);
        adv(4);   // edge 8
        check("br_e8_duty",  int'(u_if.duty),  2);
        adv(51);  // edge 59
        check("br_e59_duty", int'(u_if.duty),  14);
        check("br_e59_state", int'(u_if.state), c_ST_UP);
        adv(1);   // edge 60
        check("br_e60_duty",  int'(u_if.duty),   15);
        check("br_e60_state", int'(u_if.state),  c_ST_HIGH);
        check("br_e60_at_max", int'(u_if.at_max), 1);
        adv(7);   // edge 67
        check("br_e67_state", int'(u_if.state), c_ST_HIGH);
        adv(1);   // edge 68
        check("br_e68_state", int'(u_if.state), c_ST_DOWN);
        check("br_e68_duty",  int'(u_if.duty),  15);
        adv(4);   // edge 72
        check("br_e72_duty",  int'(u_if.duty),  14);
        adv(55);  // edge 127
        check("br_e127_duty", int'(u_if.duty),  1);
        adv(1);   // edge 128
        check("br_e128_duty",  int'(u_if.duty),   0);
        check("br_e128_state", int'(u_if.state),  c_ST_LOW);
        check("br_e128_at_min", int'(u_if.at_min), 1);
        adv(7);   // edge 135
        check("br_e135_state", int'(u_if.state), c_ST_LOW);
        adv(1);   // edge 136
        check("br_e136_state", int'(u_if.state), c_ST_UP);
        check("br_e136_duty",  int'(u_if.duty),  0);
        adv(4);   // edge 140: one period after edge 4
        check("br_e140_duty",  int'(u_if.duty),  1);

        // ---- 4: freeze with en=0 at duty 7 (prescaler mid-count) ----
        breathe_to(30);
        check("frz_pre_duty", int'(u_if.duty), 7);
        u_if.en = 1'b0;
        adv(50);
        check("frz_duty",  int'(u_if.duty),  7);
        check("frz_state", int'(u_if.state), c_ST_UP);
        u_if.en = 1'b1;
        adv(3);
        check("frz_re3_duty", int'(u_if.duty), 7);
        adv(1);
        check("frz_re4_duty", int'(u_if.duty), 8);

        // ---- 5: mode change mid-DOWN, then breathe at DMAX ----
        breathe_to(92);
        check("md_pre_duty",  int'(u_if.duty),  9);
        check("md_pre_state", int'(u_if.state), c_ST_DOWN);
        u_if.mode = 1'b0;
        u_if.inc  = 1'b1;
        adv(1);
        check("md_man_state", int'(u_if.state), c_ST_MAN);
        check("md_man_duty",  int'(u_if.duty),  9);
        adv(6);
        u_if.inc = 1'b0;
        check("md_inc_duty", int'(u_if.duty), 15);
        u_if.mode = 1'b1;
        adv(1);
        check("md_high_state", int'(u_if.state), c_ST_HIGH);
        check("md_high_duty",  int'(u_if.duty),  15);

        // ---- 6: reset mid-UP ----
        breathe_to(40);
        check("mr_pre_duty", int'(u_if.duty), 10);
        rst = 1'b1;
        adv(1);
        check("mr_duty",   int'(u_if.duty),   0);
        check("mr_state",  int'(u_if.state),  c_ST_MAN);
        check("mr_at_min", int'(u_if.at_min), 1);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end
endmodule
`default_nettype wire
